mem_ls_sequencer: RTL

MEM_LS_SEQUENCER -- requirements
Module: mem_ls_sequencer

---
 rtl/mem_ls_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mem_ls_sequencer.sv
// mem_ls_sequencer: CPU load/store sequencer onto a big-endian word memory, with
// read-modify-write for partial stores. Optional access timeout: MEM_LS_TIMEOUT_EN.
`default_nettype none

module mem_ls_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;

  state_t      state;
  logic [1:0]  lat_off;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [31:0] lat_wdata;
  logic        lat_write;
`ifdef MEM_LS_TIMEOUT_EN
  logic [7:0]  tmo_cnt;
`endif

  function automatic logic is_illegal(input logic [1:0] sz, input logic [1:0] off);
    return (sz == 2'd3) || (sz == 2'd1 && off[0]) || (sz == 2'd0 && off != 2'd0);
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] off,
                                               input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (sz)
      2'd2:    return uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'd1:    return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Only the addressed lane of the read word is replaced by the right-aligned store data.
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (sz == 2'd2) begin
      case (off)
        2'd0:    r[31:24] = d[7:0];
        2'd1:    r[23:16] = d[7:0];
        2'd2:    r[15:8]  = d[7:0];
        default: r[7:0]   = d[7:0];
      endcase
    end else if (off[1]) begin
      r[15:0] = d[15:0];
    end else begin
      r[31:16] = d[15:0];
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'd0;
      resp_error   <= 1'b0;
      lat_off      <= 2'd0;
      lat_size     <= 2'd0;
      lat_unsigned <= 1'b0;
      lat_wdata    <= 32'd0;
      lat_write    <= 1'b0;
`ifdef MEM_LS_TIMEOUT_EN
      tmo_cnt      <= 8'd0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_off      <= req_addr[1:0];
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_wdata    <= req_wdata;
            lat_write    <= req_write;
            mem_addr     <= {req_addr[31:2], 2'b00};
            req_ready    <= 1'b0;
            busy         <= 1'b1;
`ifdef MEM_LS_TIMEOUT_EN
            tmo_cnt      <= 8'd0;
`endif
            if (is_illegal(req_size, req_addr[1:0])) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= 32'd0;
            end else if (req_write && req_size == 2'd0) begin
              state     <= WRITE;
              mem_en    <= 1'b1;
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata;
            end else begin
              state  <= READ;
              mem_en <= 1'b1;
              mem_we <= 1'b0;
            end
          end
        end
        READ: begin
          if (mem_ready) begin
            if (lat_write) begin
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_wdata <= store_merge(mem_rdata, lat_off, lat_size, lat_wdata);
`ifdef MEM_LS_TIMEOUT_EN
              tmo_cnt   <= 8'd0;
`endif
            end else begin
              state      <= RESP;
              mem_en     <= 1'b0;
              resp_valid <= 1'b1;
              resp_error <= 1'b0;
              resp_rdata <= load_extract(mem_rdata, lat_off, lat_size, lat_unsigned);
            end
          end
`ifdef MEM_LS_TIMEOUT_EN
          else if (tmo_cnt == 8'd254) begin
            tmo_cnt    <= 8'd255;
            state      <= RESP;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b1;
            resp_error <= 1'b1;
            resp_rdata <= 32'd0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end
        WRITE: begin
          if (mem_ready) begin
            state      <= RESP;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= 32'd0;
          end
`ifdef MEM_LS_TIMEOUT_EN
          else if (tmo_cnt == 8'd254) begin
            tmo_cnt    <= 8'd255;
            state      <= RESP;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b1;
            resp_error <= 1'b1;
            resp_rdata <= 32'd0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
